stream_rr_arbiter: RTL and testbench

- Shares one 8-bit valid/ready stream sink (the stream_in_* side of the sample datapath) between NUM_REQ requesters.
- Uses round-robin arbitration with burst locking: a granted requester keeps the sink until it sends a beat with last, or until MAX_BURST beats have been accepted.
- The output is a single registered stage, so stream_out_* are flop outputs with no combinational path from requester inputs.

---
 rtl/stream_rr_arbiter_pkg.sv | 28 ++
 rtl/stream_rr_arbiter_if.sv | 27 ++
 rtl/stream_rr_arbiter_pick.sv | 21 ++
 rtl/stream_rr_arbiter.sv | 132 +++++++++++++
 tb/tb_stream_rr_arbiter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and the rotate-priority search used by the stream round-robin arbiter.
// The search walks outward from the last granted index so every requester gets a turn.
package stream_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int MAX_REQ   = 16;
    localparam int MAX_REQ_W = 4;

    // Returns the first set index after ptr (wrapping at num_req); ptr itself when nothing is set.
    function automatic int rr_next(input logic [MAX_REQ-1:0] valid, input int num_req, input int ptr);
        int   idx;
        logic found;
        rr_next = ptr;
        found   = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = (ptr + k) % num_req;
            if (!found && (k <= num_req) && valid[idx[MAX_REQ_W-1:0]]) begin
                rr_next = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Requester-side and sink-side valid/ready bundle shared by the arbiter and its environment.
// The slave view is the arbiter itself; the master view drives requesters and the sink.
interface stream_rr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic                          stream_out_valid;
    logic                          stream_out_ready;
    logic [DATA_WIDTH-1:0]         stream_out_data;
    logic                          stream_out_last;

    modport master (
        output req_valid, req_data, req_last, stream_out_ready,
        input  req_ready, stream_out_valid, stream_out_data, stream_out_last
    );

    modport slave (
        input  req_valid, req_data, req_last, stream_out_ready,
        output req_ready, stream_out_valid, stream_out_data, stream_out_last
    );

endinterface

// File: rtl/stream_rr_arbiter_pick.sv
// Combinational rotate-priority encoder: picks the next requesting index after the
// round-robin pointer and flags whether anybody is requesting at all.
module stream_rr_pick
    import stream_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [$clog2(NUM_REQ)-1:0] grant_o,
    output logic                       any_req_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    always_comb begin
        grant_o   = IDX_W'(rr_next(MAX_REQ'(req_i), NUM_REQ, int'(ptr_i)));
        any_req_o = |req_i;
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter with burst locking that shares one registered valid/ready sink
// between NUM_REQ requesters; a grant ends on a last beat or after MAX_BURST beats.
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    stream_rr_arbiter_if.slave         arb_if,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e            state_q, state_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;

    logic [IDX_W-1:0]      pick_idx;
    logic                  any_req;
    logic                  can_load;
    logic                  accept;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;

    stream_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i     (arb_if.req_valid),
        .ptr_i     (rr_ptr_q),
        .grant_o   (pick_idx),
        .any_req_o (any_req)
    );

    // Only the granted requester is visible to the output stage; everyone else is ignored.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_valid = arb_if.req_valid[i];
                sel_last  = arb_if.req_last[i];
                sel_data  = arb_if.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        rr_ptr_d         = rr_ptr_q;
        beat_cnt_d       = beat_cnt_q;
        out_valid_d      = out_valid_q;
        out_data_d       = out_data_q;
        out_last_d       = out_last_q;
        arb_if.req_ready = '0;
        accept           = 1'b0;
        can_load         = !out_valid_q || arb_if.stream_out_ready;

        // A held beat drains in either state.
        if (arb_if.stream_out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    arb_if.req_ready[i] = (grant_q == IDX_W'(i)) && can_load;
                end
                accept = sel_valid && can_load;
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = sel_data;
                    out_last_d  = sel_last;
                    beat_cnt_d  = beat_cnt_q + CNT_W'(1);
                    if (sel_last || (beat_cnt_q == CNT_W'(MAX_BURST - 1))) begin
                        rr_ptr_d = grant_q;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign arb_if.stream_out_valid = out_valid_q;
    assign arb_if.stream_out_data  = out_data_q;
    assign arb_if.stream_out_last  = out_last_q;
    assign grant_id                = grant_q;
    assign busy                    = (state_q == GRANT);

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter: directed scenarios with constant expectations,
// then randomized traffic against a transaction-level model and an output scoreboard.
module tb_stream_rr_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 4;
    localparam int IDX_W      = 2;
    localparam int WAIT_BOUND = (NUM_REQ - 1) * (MAX_BURST + 1);

    typedef struct {
        int         src;
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [IDX_W-1:0] grant_id;
    logic             busy;

    logic [3:0] vld;
    logic [3:0] lst;
    logic [7:0] dat [NUM_REQ];
    logic       sinkRdy;

    int testsRun    = 0;
    int testsFailed = 0;

    stream_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

    stream_rr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .arb_if   (bus),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus();
        bus.req_valid        = vld;
        bus.req_last         = lst;
        bus.stream_out_ready = sinkRdy;
        for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] = dat[i];
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        vld = '0;
        lst = '0;
        sinkRdy = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) dat[i] = '0;
        applyStimulus();
        stepClk();
        stepClk();
        rst = 1'b0;
        applyStimulus();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vld = 4'hF;
        lst = 4'hF;
        sinkRdy = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) dat[i] = 8'h55;
        applyStimulus();
        stepClk();
        stepClk();
        testsRun++;
        if (bus.stream_out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid: got %0b, expected 0", bus.stream_out_valid); end
        testsRun++;
        if (bus.stream_out_data !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_data: got %h, expected 00", bus.stream_out_data); end
        testsRun++;
        if (bus.stream_out_last !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_last: got %0b, expected 0", bus.stream_out_last); end
        testsRun++;
        if (grant_id !== 2'd0) begin testsFailed++; $display("[TB] FAIL reset_grant_id: got %0d, expected 0", grant_id); end
        testsRun++;
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %0b, expected 0", busy); end
        testsRun++;
        if (bus.req_ready !== 4'b0000) begin testsFailed++; $display("[TB] FAIL reset_req_ready: got %b, expected 0000", bus.req_ready); end
        vld = '0;
        lst = '0;
        applyStimulus();
        stepClk();
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        doReset();
        vld = 4'hF;
        lst = 4'hF;
        for (int i = 0; i < NUM_REQ; i++) dat[i] = 8'hA0 + 8'(i);
        applyStimulus();
        for (int k = 0; k < 5; k++) begin
            automatic int idx = k % NUM_REQ;
            stepClk();
            testsRun++;
            if (busy !== 1'b1 || grant_id !== IDX_W'(idx)) begin testsFailed++; $display("[TB] FAIL rr_grant%0d: got busy=%0b id=%0d, expected busy=1 id=%0d", k, busy, grant_id, idx); end
            testsRun++;
            if (bus.stream_out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rr_bubble_valid%0d: got %0b, expected 0", k, bus.stream_out_valid); end
            testsRun++;
            if (bus.req_ready !== 4'(1 << idx)) begin testsFailed++; $display("[TB] FAIL rr_ready%0d: got %b, expected %b", k, bus.req_ready, 4'(1 << idx)); end
            stepClk();
            testsRun++;
            if (bus.stream_out_valid !== 1'b1 || bus.stream_out_data !== 8'hA0 + 8'(idx) || bus.stream_out_last !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL rr_beat%0d: got v=%0b d=%h l=%0b, expected v=1 d=%h l=1", k, bus.stream_out_valid, bus.stream_out_data, bus.stream_out_last, 8'hA0 + 8'(idx));
            end
            testsRun++;
            if (busy !== 1'b0 || bus.req_ready !== 4'b0000) begin testsFailed++; $display("[TB] FAIL rr_idle%0d: got busy=%0b ready=%b, expected busy=0 ready=0000", k, busy, bus.req_ready); end
        end
    endtask

    task automatic test_max_burst();
        automatic int   sent = 0;
        automatic logic acc;
        automatic bit   expV [9] = '{0, 1, 1, 1, 1, 0, 1, 1, 0};
        automatic bit   expB [9] = '{1, 1, 1, 1, 0, 1, 1, 0, 0};
        automatic logic [7:0] expD [9] = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h00, 8'h14, 8'h15, 8'h00};
        doReset();
        for (int cyc = 0; cyc < 9; cyc++) begin
            vld    = (sent < 6) ? 4'b0100 : 4'b0000;
            dat[2] = 8'h10 + 8'(sent);
            lst    = (sent == 5) ? 4'b0100 : 4'b0000;
            applyStimulus();
            #1;
            acc = bus.req_ready[2] && vld[2];
            stepClk();
            if (acc) sent++;
            testsRun++;
            if (bus.stream_out_valid !== expV[cyc] || busy !== expB[cyc]) begin
                testsFailed++;
                $display("[TB] FAIL burst_timing%0d: got v=%0b busy=%0b, expected v=%0b busy=%0b", cyc, bus.stream_out_valid, busy, expV[cyc], expB[cyc]);
            end
            if (expV[cyc]) begin
                testsRun++;
                if (bus.stream_out_data !== expD[cyc] || bus.stream_out_last !== (expD[cyc] == 8'h15)) begin
                    testsFailed++;
                    $display("[TB] FAIL burst_beat%0d: got d=%h l=%0b, expected d=%h l=%0b", cyc, bus.stream_out_data, bus.stream_out_last, expD[cyc], expD[cyc] == 8'h15);
                end
            end
            testsRun++;
            if (grant_id !== 2'd2) begin testsFailed++; $display("[TB] FAIL burst_grant%0d: got %0d, expected 2", cyc, grant_id); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] got [$];
        doReset();
        sinkRdy = 1'b0;
        vld     = 4'b0001;
        dat[0]  = 8'hA5;
        applyStimulus();
        stepClk();
        testsRun++;
        if (bus.req_ready !== 4'b0001) begin testsFailed++; $display("[TB] FAIL bp_first_ready: got %b, expected 0001", bus.req_ready); end
        stepClk();
        dat[0] = 8'h5A;
        lst    = 4'b0001;
        applyStimulus();
        for (int c = 0; c < 3; c++) begin
            #1;
            testsRun++;
            if (bus.req_ready !== 4'b0000) begin testsFailed++; $display("[TB] FAIL bp_ready%0d: got %b, expected 0000", c, bus.req_ready); end
            stepClk();
            testsRun++;
            if (bus.stream_out_valid !== 1'b1 || bus.stream_out_data !== 8'hA5) begin
                testsFailed++;
                $display("[TB] FAIL bp_hold%0d: got v=%0b d=%h, expected v=1 d=a5", c, bus.stream_out_valid, bus.stream_out_data);
            end
        end
        sinkRdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            automatic logic acc;
            applyStimulus();
            #1;
            if (bus.stream_out_valid) got.push_back(bus.stream_out_data);
            acc = vld[0] && bus.req_ready[0];
            stepClk();
            if (acc) vld = 4'b0000;
        end
        testsRun++;
        if (got.size() != 2) begin
            testsFailed++;
            $display("[TB] FAIL bp_count: got %0d beats, expected 2", got.size());
        end else if (got[0] !== 8'hA5 || got[1] !== 8'h5A) begin
            testsFailed++;
            $display("[TB] FAIL bp_order: got %h %h, expected a5 5a", got[0], got[1]);
        end
    endtask

    task automatic test_reset_mid_burst();
        doReset();
        vld    = 4'b0010;
        dat[1] = 8'h31;
        applyStimulus();
        stepClk();
        stepClk();
        dat[1] = 8'h32;
        applyStimulus();
        stepClk();
        testsRun++;
        if (bus.stream_out_valid !== 1'b1 || busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL midrst_pre: got v=%0b busy=%0b, expected 1 1", bus.stream_out_valid, busy); end
        rst    = 1'b1;
        vld    = 4'b1010;
        dat[3] = 8'h77;
        applyStimulus();
        stepClk();
        testsRun++;
        if (bus.stream_out_valid !== 1'b0 || busy !== 1'b0 || bus.req_ready !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL midrst_after: got v=%0b busy=%0b ready=%b, expected 0 0 0000", bus.stream_out_valid, busy, bus.req_ready);
        end
        rst = 1'b0;
        applyStimulus();
        #1;
        testsRun++;
        if (bus.req_ready !== 4'b0000) begin testsFailed++; $display("[TB] FAIL midrst_idle_ready: got %b, expected 0000", bus.req_ready); end
        stepClk();
        testsRun++;
        if (grant_id !== 2'd1 || busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL midrst_regrant: got id=%0d busy=%0b, expected 1 1", grant_id, busy); end
    endtask

    task automatic test_hold_on_drop();
        doReset();
        vld    = 4'b1000;
        dat[3] = 8'hC0;
        applyStimulus();
        stepClk();
        testsRun++;
        if (grant_id !== 2'd3) begin testsFailed++; $display("[TB] FAIL hold_grant3: got %0d, expected 3", grant_id); end
        stepClk();
        vld    = 4'b0001;
        dat[0] = 8'h0F;
        lst    = 4'b0001;
        applyStimulus();
        for (int c = 0; c < 5; c++) begin
            #1;
            testsRun++;
            if (bus.req_ready[0] !== 1'b0) begin testsFailed++; $display("[TB] FAIL hold_ready0_%0d: got %0b, expected 0", c, bus.req_ready[0]); end
            stepClk();
            testsRun++;
            if (busy !== 1'b1 || grant_id !== 2'd3) begin testsFailed++; $display("[TB] FAIL hold_keep%0d: got busy=%0b id=%0d, expected 1 3", c, busy, grant_id); end
        end
        vld    = 4'b1001;
        dat[3] = 8'hC1;
        lst    = 4'b1001;
        applyStimulus();
        #1;
        testsRun++;
        if (bus.req_ready !== 4'b1000) begin testsFailed++; $display("[TB] FAIL hold_resume_ready: got %b, expected 1000", bus.req_ready); end
        stepClk();
        testsRun++;
        if (bus.stream_out_data !== 8'hC1 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL hold_release: got d=%h busy=%0b, expected c1 0", bus.stream_out_data, busy); end
        vld = 4'b0001;
        applyStimulus();
        stepClk();
        testsRun++;
        if (grant_id !== 2'd0 || busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL hold_next: got id=%0d busy=%0b, expected 0 1", grant_id, busy); end
        #1;
        testsRun++;
        if (bus.req_ready !== 4'b0001) begin testsFailed++; $display("[TB] FAIL hold_next_ready: got %b, expected 0001", bus.req_ready); end
    endtask

    // Model keeps who owns the sink, how many beats it has sent and what sits in the output slot.
    task automatic test_random(input int cycles, input bit fair);
        automatic bit         mOwned = 0;
        automatic int         mOwner = 0;
        automatic int         mGrant = 0;
        automatic int         mPtr = NUM_REQ - 1;
        automatic int         mBeats = 0;
        automatic logic       mOutValid = 1'b0;
        automatic logic [7:0] mOutData = 8'h00;
        automatic logic       mOutLast = 1'b0;
        automatic bit         inBurst = 0;
        automatic int         burstSrc = 0;
        automatic int         burstLen = 0;
        automatic int         waitCnt [NUM_REQ] = '{default: 0};
        beat_t                expQ [$];
        doReset();
        for (int cyc = 0; cyc < cycles; cyc++) begin
            automatic logic [3:0] expRdy;
            automatic logic [3:0] accNow;
            automatic bit         canLoad;
            automatic bit         acc;
            automatic int         pick = -1;
            automatic int         server;
            automatic beat_t      b;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!vld[i]) begin
                    vld[i] = fair ? 1'b1 : ($urandom_range(0, 99) < 40);
                    dat[i] = 8'($urandom);
                    lst[i] = ($urandom_range(0, 3) == 0);
                end
            end
            sinkRdy = fair ? 1'b1 : ($urandom_range(0, 99) < 70);
            applyStimulus();
            #1;
            canLoad = !mOutValid || sinkRdy;
            expRdy  = (mOwned && canLoad) ? 4'(1 << mOwner) : 4'b0000;
            testsRun++;
            if (bus.req_ready !== expRdy) begin testsFailed++; $display("[TB] FAIL rnd_ready@%0d: got %b, expected %b", cyc, bus.req_ready, expRdy); end
            if (bus.stream_out_valid && sinkRdy) begin
                testsRun++;
                if (expQ.size() == 0) begin
                    testsFailed++;
                    $display("[TB] FAIL rnd_sb_extra@%0d: got beat %h, expected none", cyc, bus.stream_out_data);
                end else begin
                    b = expQ.pop_front();
                    if (bus.stream_out_data !== b.data || bus.stream_out_last !== b.last) begin
                        testsFailed++;
                        $display("[TB] FAIL rnd_sb@%0d: got d=%h l=%0b, expected d=%h l=%0b", cyc, bus.stream_out_data, bus.stream_out_last, b.data, b.last);
                    end
                    if (inBurst) begin
                        testsRun++;
                        if (b.src != burstSrc) begin testsFailed++; $display("[TB] FAIL rnd_interleave@%0d: got src %0d, expected %0d", cyc, b.src, burstSrc); end
                    end else begin
                        inBurst  = 1;
                        burstSrc = b.src;
                        burstLen = 0;
                    end
                    burstLen++;
                    if (b.last || burstLen == MAX_BURST) inBurst = 0;
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                accNow[i] = vld[i] && bus.req_ready[i];
                if (accNow[i]) expQ.push_back('{src: i, data: dat[i], last: lst[i]});
            end
            if (!mOwned) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    automatic int idx = (mPtr + k) % NUM_REQ;
                    if (pick < 0 && vld[idx]) pick = idx;
                end
            end
            server = mOwned ? mOwner : pick;
            if (fair) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (i == server) begin
                        waitCnt[i] = 0;
                    end else if (vld[i]) begin
                        waitCnt[i]++;
                        testsRun++;
                        if (waitCnt[i] > WAIT_BOUND) begin testsFailed++; $display("[TB] FAIL rnd_starve@%0d: requester %0d waited %0d, expected <= %0d", cyc, i, waitCnt[i], WAIT_BOUND); end
                    end
                end
            end
            acc = mOwned && vld[mOwner] && canLoad;
            if (acc) begin
                mOutValid = 1'b1;
                mOutData  = dat[mOwner];
                mOutLast  = lst[mOwner];
            end else if (sinkRdy) begin
                mOutValid = 1'b0;
            end
            if (!mOwned) begin
                if (pick >= 0) begin
                    mOwned = 1;
                    mOwner = pick;
                    mGrant = pick;
                    mBeats = 0;
                end
            end else if (acc) begin
                mBeats++;
                if (lst[mOwner] || mBeats == MAX_BURST) begin
                    mOwned = 0;
                    mPtr   = mOwner;
                end
            end
            stepClk();
            testsRun++;
            if (bus.stream_out_valid !== mOutValid || bus.stream_out_data !== mOutData || bus.stream_out_last !== mOutLast) begin
                testsFailed++;
                $display("[TB] FAIL rnd_out@%0d: got v=%0b d=%h l=%0b, expected v=%0b d=%h l=%0b", cyc, bus.stream_out_valid, bus.stream_out_data, bus.stream_out_last, mOutValid, mOutData, mOutLast);
            end
            testsRun++;
            if (grant_id !== IDX_W'(mGrant) || busy !== mOwned) begin
                testsFailed++;
                $display("[TB] FAIL rnd_grant@%0d: got id=%0d busy=%0b, expected id=%0d busy=%0b", cyc, grant_id, busy, mGrant, mOwned);
            end
            for (int i = 0; i < NUM_REQ; i++) if (accNow[i]) vld[i] = 1'b0;
        end
    endtask

    initial begin
        vld = '0;
        lst = '0;
        sinkRdy = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) dat[i] = '0;
        applyStimulus();
        test_reset();
        test_round_robin();
        test_max_burst();
        test_backpressure();
        test_reset_mid_burst();
        test_hold_on_drop();
        test_random(10000, 1'b0);
        test_random(2000, 1'b1);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
